// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and types for the fetch stage
//
// Contents:
//   fetch_state_t : FSM state encoding (FETCH, FLUSH)
//   PC_INCR       : sequential PC step in bytes
//   NOP_INSTR     : canonical NOP encoding (addi x0, x0, 0)
package fetch_stage_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_INCR   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry pc/instr holding register for the fetch stage
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture load_pc/load_instr and set valid
//   load_pc         : PC of the instruction being captured
//   load_instr      : instruction being captured
//   clear           : drop the held entry (pop or flush); wins over load
//   valid           : an entry is held
//   pc, instr       : the held entry
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  input  logic            clear,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= XLEN'(NOP_INSTR);
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid entry and redirect flush
//
// Parameters:
//   XLEN      : address / instruction width
//   RESET_PC  : PC loaded on reset
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : hold the IF/ID register (hazard unit)
//   redirect_valid    : branch/jump taken this cycle, target on redirect_pc
//   imem_req/addr     : instruction memory request, held stable until imem_ack
//   imem_ack/rdata    : request complete with fetched instruction (may ack in the req cycle)
//   if_id_valid/pc/instr : IF/ID pipeline register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  // Address of the request that was in flight when a redirect arrived;
  // it must stay on the bus until the memory completes it.
  logic [XLEN-1:0] flush_addr;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;
  logic            skid_load;
  logic            skid_clear;
  logic            hs;
  logic            fetch_hs;

  // While FETCH holds a skid entry there is nowhere to put another
  // instruction, so the request is withheld until the entry drains.
  assign imem_req  = !rst && ((state == FLUSH) || !skid_valid);
  assign imem_addr = (state == FLUSH) ? flush_addr : pc;

  assign hs       = imem_req && imem_ack;
  // Only a completion in FETCH carries a usable instruction; FLUSH data is stale.
  assign fetch_hs = hs && (state == FETCH);

  // A fetch request is only issued with the skid empty, so a stalled
  // completion always has room.
  assign skid_load  = fetch_hs && stall && !redirect_valid;
  assign skid_clear = redirect_valid || (!stall && skid_valid);

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .load_pc   (pc),
    .load_instr(imem_rdata),
    .clear     (skid_clear),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      flush_addr  <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else begin
      // PC and FSM
      if (redirect_valid) begin
        pc <= redirect_pc;
        if (imem_req && !imem_ack) begin
          // Request still in flight: wait it out in FLUSH. A redirect
          // already in FLUSH keeps the original stale address.
          state <= FLUSH;
          if (state == FETCH) begin
            flush_addr <= pc;
          end
        end else begin
          state <= FETCH;
        end
      end else if (hs) begin
        if (state == FETCH) begin
          pc <= pc + XLEN'(PC_INCR);
        end
        state <= FETCH;
      end

      // IF/ID register
      if (redirect_valid) begin
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (skid_valid) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= skid_pc;
          if_id_instr <= skid_instr;
        end else if (fetch_hs) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= pc;
          if_id_instr <= imem_rdata;
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam int          LAT    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } rec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: fetched-but-undelivered instructions in program order,
  // the next architectural fetch address, and a pending stale request.
  ent_t        pend_q[$];
  rec_t        exp_q[$];
  logic [31:0] model_pc = RST_PC;
  bit          stale = 0;
  logic [31:0] stale_addr = '0;
  bit          m_valid = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  int          req_age = 0;
  int          mode = 0;  // 0: ack tied high, 1: fixed latency, 2: random

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
    logic        req;
    logic [31:0] addr;
    logic [31:0] cur;
    bit          ack;
    bit          hs;
    ent_t        e;
    rec_t        rec;
    @(negedge clk);
    rst            = r;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    if (r) begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      pend_q.delete();
      stale    = 0;
      model_pc = RST_PC;
      m_valid  = 0;
      m_pc     = '0;
      m_instr  = '0;
      req_age  = 0;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RST_PC);
      rec.rst = 1; rec.valid = 0; rec.pc = '0; rec.instr = '0;
    end else begin
      req  = imem_req;
      addr = imem_addr;
      cur  = stale ? stale_addr : model_pc;
      check("imem_req", 32'(req), 32'(stale || (pend_q.size() == 0)));
      if (req) check("imem_addr", addr, cur);
      case (mode)
        0:       ack = 1;
        1:       ack = req && (req_age >= LAT - 1);
        default: ack = req && ($urandom_range(0, 2) == 0);
      endcase
      imem_ack   = ack;
      imem_rdata = ack ? mem_word(addr) : $urandom;
      hs = req && ack;
      if (hs) begin
        if (stale) stale = 0;
        else begin
          e.pc = model_pc; e.instr = mem_word(model_pc);
          pend_q.push_back(e);
          model_pc = model_pc + 32'd4;
        end
      end
      if (rd) begin
        pend_q.delete();
        if (req && !ack) begin
          stale      = 1;
          stale_addr = cur;
        end
        model_pc = rpc;
        m_valid  = 0;
      end else if (!st) begin
        if (pend_q.size() > 0) begin
          e       = pend_q.pop_front();
          m_valid = 1;
          m_pc    = e.pc;
          m_instr = e.instr;
        end else begin
          m_valid = 0;
        end
      end
      req_age = (hs || !req) ? 0 : req_age + 1;
      rec.rst = 0; rec.valid = m_valid; rec.pc = m_pc; rec.instr = m_instr;
    end
    exp_q.push_back(rec);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin : monitor
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("if_id_valid", 32'(if_id_valid), 32'(r.valid));
        if (r.valid || r.rst) begin
          check("if_id_pc", if_id_pc, r.pc);
          check("if_id_instr", if_id_instr, r.instr);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    bit          found;
    bit          r_b, st_b, rd_b;
    logic [31:0] tgt;
    logic [31:0] exp_stale;

    // Reset
    mode = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
    check("reset_addr", imem_addr, RST_PC);
    check("reset_if_id_pc", if_id_pc, 32'd0);

    // Zero-wait streaming from RESET_PC
    step(0, 0, 0, '0);
    check("stream_valid", 32'(if_id_valid), 32'd1);
    check("stream_pc0", if_id_pc, RST_PC);
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0, '0);
      check("stream_pc", if_id_pc, RST_PC + 32'(4 * k));
    end

    // Stall with skid capture
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, '0);
      check("stall_hold_pc", if_id_pc, RST_PC + 32'd12);
      check("stall_req_low", 32'(imem_req), 32'd0);
    end
    step(0, 0, 0, '0);
    check("skid_deliver_pc", if_id_pc, RST_PC + 32'd16);
    step(0, 0, 0, '0);
    check("after_skid_pc", if_id_pc, RST_PC + 32'd20);

    // Redirect with simultaneous ack
    step(0, 0, 1, 32'h100);
    check("redir_ack_valid", 32'(if_id_valid), 32'd0);
    check("redir_ack_addr", imem_addr, 32'h100);
    step(0, 0, 0, '0);
    check("redir_ack_first_pc", if_id_pc, 32'h100);

    // Redirect against a 3-cycle memory in the first request cycle
    mode  = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_req && req_age == 0) found = 1;
      else step(0, 0, 0, '0);
    end
    check("flush_fresh_req_found", 32'(found), 32'd1);
    exp_stale = model_pc;
    step(0, 0, 1, 32'h100);
    check("flush_req", 32'(imem_req), 32'd1);
    check("flush_addr_stale0", imem_addr, exp_stale);
    step(0, 0, 0, '0);
    check("flush_addr_stale1", imem_addr, exp_stale);
    step(0, 0, 0, '0);
    check("flush_addr_target", imem_addr, 32'h100);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(0, 0, 0, '0);
      if (if_id_valid) found = 1;
    end
    check("flush_delivered", 32'(found), 32'd1);
    check("flush_first_pc", if_id_pc, 32'h100);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) mode = $urandom_range(0, 2);
      r_b  = ($urandom_range(0, 299) == 0);
      st_b = ($urandom_range(0, 9) < 3);
      rd_b = ($urandom_range(0, 19) == 0);
      tgt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                          : ($urandom & 32'h0000_0FFC);
      step(r_b, st_b, rd_b, tgt);
    end

    // PC wrap
    mode = 0;
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, '0);
    check("wrap_addr_zero", imem_addr, 32'd0);
    check("wrap_top_pc", if_id_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, '0);
    check("wrap_zero_pc", if_id_pc, 32'd0);

    // Reset with skid full, restart from RESET_PC
    step(0, 1, 0, '0);
    check("pre_rst_skid_full", 32'(imem_req), 32'd0);
    step(1, 0, 0, '0);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", imem_addr, RST_PC);
    check("midrst_valid", 32'(if_id_valid), 32'd0);
    check("midrst_pc", if_id_pc, 32'd0);
    check("midrst_instr", if_id_instr, 32'd0);
    step(0, 0, 0, '0);
    check("restart_valid", 32'(if_id_valid), 32'd1);
    check("restart_pc", if_id_pc, RST_PC);
    step(0, 0, 0, '0);

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-003 SHALL have ports clk input 1, the single clock, all state on its rising edge.
REQ-004 SHALL have port rst input 1; reset is asynchronous and active-high.
REQ-005 SHALL have port stall input 1, meaning hold the IF/ID register (from the hazard unit).
REQ-006 SHALL have port redirect_valid input 1, meaning branch/jump taken this cycle.
REQ-007 SHALL have port redirect_pc input XLEN, the redirect target.
REQ-008 SHALL have port imem_req output 1, an instruction memory request.
REQ-009 SHALL have port imem_addr output XLEN, the request address.
REQ-010 SHALL have port imem_ack input 1, meaning rdata valid and request complete; ack is permitted in the same cycle as req.
REQ-011 SHALL have port imem_rdata input XLEN, the fetched instruction.
REQ-012 SHALL have port if_id_valid output 1, meaning the IF/ID register holds a live instruction.
REQ-013 SHALL have port if_id_pc output XLEN, the PC of the held instruction.
REQ-014 SHALL have port if_id_instr output XLEN, the held instruction.

Function
REQ-015 SHALL implement FSM states FETCH and FLUSH; reset state is FETCH.
REQ-016 SHALL, in FETCH, drive imem_req = !skid_valid, with imem_addr = pc.
REQ-017 SHALL, once imem_req is asserted, hold req and imem_addr stable until imem_ack; at most one request is outstanding.
REQ-018 SHALL, on ack in FETCH with no redirect, increment pc by 4 (modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL, on ack, load if_id from the data when !stall and skid is empty (latency: ack cycle -> if_id_valid next edge), else capture into a 1-entry skid buffer (pc, instr).
REQ-020 SHALL, when !stall and skid_valid, load if_id from skid and clear skid_valid; imem_req stays low that cycle.
REQ-021 SHALL, when !stall and no data is available, clear if_id_valid; when stall, leave if_id unchanged.
REQ-022 SHALL give redirect_valid priority over stall and ack: on the next edge clear if_id_valid and skid_valid, and set pc = redirect_pc.
REQ-023 SHALL, on redirect with ack in the same cycle or no request outstanding, discard the data and remain in FETCH.
REQ-024 SHALL, on redirect while a request is outstanding without ack, go to FLUSH.
REQ-025 SHALL, in FLUSH, keep imem_req=1 and imem_addr at the stale address until ack, discard that data, then return to FETCH fetching pc.
REQ-026 SHALL, on a further redirect in FLUSH, overwrite pc with the new target and remain in FLUSH.
REQ-027 SHALL never deliver an instruction fetched before a redirect after that redirect.

Reset
REQ-028 SHALL, while rst=1, force imem_req=0, if_id_valid=0, skid_valid=0, pc=RESET_PC, imem_addr=RESET_PC, if_id_pc=0, if_id_instr=0 (NOP encoding 32'h0000_0013 is permitted, but 0 is the fixed value), state=FETCH.
REQ-029 SHALL, on reset mid-request, abandon the request; imem SHALL be reset concurrently.
REQ-030 SHALL assert imem_req in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the state encoding (FETCH/FLUSH), the PC increment constant 4, and the NOP encoding in the shared pipeline package.
REQ-032 SHALL contain one sub-module, fetch_skid_buf (1-entry pc/instr holding register with valid), with the FSM and PC in the top.

Verification
REQ-033 SHALL verify zero-wait streaming: ack tied high, no stall -> if_id_pc sequence 0,4,8,12 on consecutive cycles, if_id_valid=1 from cycle 2.
REQ-034 SHALL verify stall with skid: stall held 3 cycles while pc=8 is fetched -> if_id holds pc=4, skid holds pc=8, imem_req=0; after release, pc=8 is delivered and then pc=12.
REQ-035 SHALL verify redirect with simultaneous ack: redirect_pc=0x100 -> the acked data is discarded, if_id_valid=0 next cycle, next imem_addr=0x100.
REQ-036 SHALL verify redirect with a 3-cycle-latency memory: redirect at request cycle 1 -> FLUSH, addr held stale until ack, data dropped, then imem_addr=0x100 and the first delivered if_id_pc=0x100.
REQ-037 SHALL verify reset mid-operation: rst pulsed with skid full -> all outputs at reset values, restart from RESET_PC=0x80 with parameter override.
REQ-038 SHALL verify wrap: pc=32'hFFFF_FFFC is acked -> next imem_addr=0.
